// File: rtl/fml_pkg.sv
// Shared constants for the FML burst responder: burst geometry and FSM encoding.
package fml_pkg;

    localparam int BURST_LEN = 8;
    localparam int BEAT_W    = 3;
    localparam int ST_W      = 2;

    localparam logic [ST_W-1:0] S_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] S_WAIT  = 2'd1;
    localparam logic [ST_W-1:0] S_BURST = 2'd2;

endpackage

// File: rtl/fml_ram.sv
// Single-port 2^mem_aw x 16 RAM with byte write enables and a registered read port.
module fml_ram #(
    parameter int mem_aw = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [mem_aw-1:0] addr,
    input  logic [1:0]        we,
    input  logic [15:0]       wdata,
    input  logic              re,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**mem_aw];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
    end

    // Read register only loads on re so it holds its value across write bursts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 16'h0000;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fml_burst_responder.sv
// FML slave answering fixed 8-word bursts from an internal RAM after ack_lat cycles.
module fml_burst_responder
    import fml_pkg::*;
#(
    parameter int fml_depth = 20,
    parameter int mem_aw    = 12,
    parameter int ack_lat   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [fml_depth-1:0] fml_adr,
    input  logic                 fml_stb,
    input  logic                 fml_we,
    input  logic [1:0]           fml_sel,
    input  logic [15:0]          fml_do,
    output logic                 fml_ack,
    output logic [15:0]          fml_di,
    output logic                 busy
);

    localparam logic [2:0] LAT_M1 = 3'(ack_lat - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [mem_aw-4:0] base_q, base_d;
    logic              we_q, we_d;

    logic [mem_aw-4:0] adr_base;
    logic [mem_aw-1:0] ram_addr;
    logic [1:0]        ram_we;
    logic              ram_re;
    logic              unused_adr_bits;

    assign adr_base        = fml_adr[mem_aw:4];
    assign unused_adr_bits = ^{fml_adr[3:0], fml_adr[fml_depth-1:mem_aw+1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        base_d   = base_q;
        we_d     = we_q;
        ram_addr = {base_q, beat_q};
        ram_we   = 2'b00;
        ram_re   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ram_addr = {adr_base, 3'b000};
                if (fml_stb) begin
                    base_d = adr_base;
                    we_d   = fml_we;
                    beat_d = '0;
                    cnt_d  = LAT_M1;
                    if (ack_lat == 1) begin
                        state_d = S_BURST;
                        ram_re  = !fml_we;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Word 0 is fetched in the last wait cycle so it lands with the ack.
                ram_addr = {base_q, 3'b000};
                cnt_d    = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_BURST;
                    cnt_d   = 3'd0;
                    ram_re  = !we_q;
                end
            end
            S_BURST: begin
                if (we_q) begin
                    ram_addr = {base_q, beat_q};
                    ram_we   = fml_sel;
                end else begin
                    ram_addr = {base_q, BEAT_W'(beat_q + 1'b1)};
                    ram_re   = (beat_q != BEAT_W'(BURST_LEN - 1));
                end
                beat_d = BEAT_W'(beat_q + 1'b1);
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            beat_q  <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            we_q    <= we_d;
        end
    end

    assign fml_ack = (state_q == S_BURST) && (beat_q == '0);
    assign busy    = (state_q != S_IDLE);

    fml_ram #(.mem_aw(mem_aw)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (fml_do),
        .re    (ram_re),
        .rdata (fml_di)
    );

endmodule
